lfsr_stream_cipher: RTL

//  Hardware LFSR stream cipher engine; parametrised successor to the software-only message encrypt/decrypt flow.

---
 rtl/crypto_pkg.sv | 23 ++
 rtl/lfsr_stream_cipher_if.sv | 45 ++++
 rtl/lfsr_stream_cipher_lfsr_gen.sv | 31 +++
 rtl/lfsr_stream_cipher.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the LFSR stream cipher engine.
//   state_t      : frame sequencer states
//   PAD_CHAR_DEF : default pad symbol for preamble/trailer bytes
//   LFSR_TAPS    : catalogue of known-good 8-bit feedback tap masks that
//                  software may hand to the engine
package crypto_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PRE  = 3'd2,
        MSG  = 3'd3,
        POST = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [7:0] PAD_CHAR_DEF = 8'h20;

    localparam logic [7:0] LFSR_TAPS [8] = '{
        8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
    };

endpackage

// File: rtl/lfsr_stream_cipher_if.sv
// Bus bundle for lfsr_stream_cipher: frame configuration, the input and
// output symbol streams, and frame status.
//   master : the side that configures frames, feeds input and sinks output
//   slave  : the cipher engine
//
// Stream handshake (both directions): a symbol transfers on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps
// its data stable until the transfer happens; ready may depend on valid's
// source state but valid never waits for ready.
interface lfsr_stream_cipher_if #(
    parameter int W  = 8,
    parameter int PL = 6
);
    logic          go;
    logic          mode;
    logic [W-1:0]  taps;
    logic [W-1:0]  seed;
    logic [PL-1:0] pre_len;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output go, mode, taps, seed, pre_len,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  busy, done, err
    );

    modport slave (
        input  go, mode, taps, seed, pre_len,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output busy, done, err
    );
endinterface

// File: rtl/lfsr_stream_cipher_lfsr_gen.sv
// Keystream register for the stream cipher.
//   CLK   : clock
//   start : synchronous active-high reset, clears the register to 0
//   load  : copy seed into the register
//   seed  : initial state
//   step  : advance one position (shift left, parity of state&taps enters LSB)
//   taps  : feedback tap mask
//   state : current keystream symbol
module lfsr_gen #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         start,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    input  logic [W-1:0] taps,
    output logic [W-1:0] state
);

    always_ff @(posedge CLK) begin
        if (start) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= {state[W-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher engine.
// Encrypt: frames MSG_LEN message symbols between a pre_len-symbol PAD_CHAR
// preamble and a PAD_CHAR trailer up to FRAME_LEN symbols, XORing every frame
// symbol with the keystream. Decrypt: takes FRAME_LEN cipher symbols and
// returns the MSG_LEN recovered message symbols.
// Ports:
//   CLK       : clock
//   start     : synchronous active-high reset
//   bus       : lfsr_stream_cipher_if.slave (config, in/out streams, status)
//   dbg_state : current sequencer state
// Build option: define STRIP_LEAD_EN to make decrypt drop recovered PAD_CHAR
// symbols at the head of the message until the first non-pad symbol.
module lfsr_stream_cipher
    import crypto_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           MSG_LEN   = 41,
    parameter int           FRAME_LEN = 64,
    parameter logic [W-1:0] PAD_CHAR  = W'(PAD_CHAR_DEF)
) (
    input  logic                CLK,
    input  logic                start,
    lfsr_stream_cipher_if.slave bus,
    output state_t              dbg_state
);

    localparam int PL = $clog2(FRAME_LEN);
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam logic [IW-1:0] FRAME_END = IW'(FRAME_LEN);
    localparam logic [IW-1:0] MSG_LEN_I = IW'(MSG_LEN);
    localparam logic [IW-1:0] MAX_PRE   = IW'(FRAME_LEN - MSG_LEN);

    state_t        state;
    logic          mode_q;
    logic [W-1:0]  taps_q;
    logic [W-1:0]  seed_q;
    logic [PL-1:0] pre_q;
    logic [IW-1:0] idx;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [W-1:0]  ks;
    logic [IW-1:0] idx_next;
    logic [IW-1:0] pre_end;
    logic [IW-1:0] msg_end;
    logic          beats_left;
    logic          slot_free;
    logic          consumes;
    logic          in_ready;
    logic          in_fire;
    logic          gen_beat;
    logic          beat;
    logic [W-1:0]  rec;
    logic          drop;
    logic          emit;
    logic [W-1:0]  emit_data;
    logic          cfg_bad;

    lfsr_gen #(.W(W)) u_lfsr (
        .CLK   (CLK),
        .start (start),
        .load  (state == LOAD),
        .seed  (seed_q),
        .step  (beat),
        .taps  (taps_q),
        .state (ks)
    );

    assign idx_next = idx + IW'(1);
    assign pre_end  = IW'(pre_q);
    assign msg_end  = pre_end + MSG_LEN_I;
    // POST stays resident after the last beat until the output slot drains.
    assign beats_left = (state == PRE) || (state == MSG) ||
                        ((state == POST) && (idx != FRAME_END));
    assign slot_free  = !out_valid_q || bus.out_ready;

    // Decrypt eats input in every beat; encrypt only during the message.
    assign consumes = beats_left && (mode_q || (state == MSG));
    assign in_ready = consumes && slot_free;
    assign in_fire  = bus.in_valid && in_ready;
    // Encrypt pad beats need only room in the output slot.
    assign gen_beat = beats_left && !mode_q && (state != MSG) && slot_free;
    assign beat     = in_fire || gen_beat;
    assign rec      = bus.in_data ^ ks;

`ifdef STRIP_LEAD_EN
    logic lead_q;

    assign drop = mode_q && (state == MSG) && lead_q && (rec == PAD_CHAR);

    // Cleared by the first non-pad recovered symbol of the message.
    always_ff @(posedge CLK) begin
        if (start) begin
            lead_q <= 1'b0;
        end else if (state == LOAD) begin
            lead_q <= 1'b1;
        end else if ((state == MSG) && in_fire && (rec != PAD_CHAR)) begin
            lead_q <= 1'b0;
        end
    end
`else
    assign drop = 1'b0;
`endif

    assign emit      = gen_beat || (in_fire && (state == MSG) && !drop);
    assign emit_data = gen_beat ? (PAD_CHAR ^ ks) : rec;

    assign cfg_bad = (seed_q == '0) || (pre_q == '0) || (pre_end > MAX_PRE);

    always_ff @(posedge CLK) begin
        if (start) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            taps_q      <= '0;
            seed_q      <= '0;
            pre_q       <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= emit_data;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (beat) begin
                idx <= idx_next;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        state  <= LOAD;
                        mode_q <= bus.mode;
                        taps_q <= bus.taps;
                        seed_q <= bus.seed;
                        pre_q  <= bus.pre_len;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    idx <= '0;
                    if (cfg_bad) begin
                        state  <= DONE;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state <= PRE;
                    end
                end
                PRE: begin
                    if (beat && (idx_next == pre_end)) begin
                        state <= MSG;
                    end
                end
                MSG: begin
                    if (beat && (idx_next == msg_end)) begin
                        state <= POST;
                    end
                end
                POST: begin
                    if ((idx == FRAME_END) && slot_free) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;

endmodule
